// File: rtl/serial_comparator.sv
// Chunk-serial magnitude comparator: A/B arrive MSB slice first, verdict is registered.
// Optional macro SERIAL_COMPARATOR_SIGNED_EN selects two's-complement comparison.
module serial_comparator #(
  parameter int WORD_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   chunk_valid_i,
  output logic                   chunk_ready_o,
  input  logic [CHUNK_WIDTH-1:0] a_chunk_i,
  input  logic [CHUNK_WIDTH-1:0] b_chunk_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic                   above_o,
  output logic                   below_o
);

  localparam int NUM_CHUNKS = (WORD_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH - WORD_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0]       LAST_CNT   = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [CHUNK_WIDTH-1:0] BEAT0_MASK = {CHUNK_WIDTH{1'b1}} >> PAD_WIDTH;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
  localparam int SIGN_POS = (WORD_WIDTH - 1) % CHUNK_WIDTH;
`endif

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_e;

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             acc_above_r;
  logic             acc_below_r;

  logic [CHUNK_WIDTH-1:0] a_eff_s;
  logic [CHUNK_WIDTH-1:0] b_eff_s;
  logic                   slice_above_s;
  logic                   slice_below_s;
  logic                   acc_above_nx_s;
  logic                   acc_below_nx_s;
  logic                   beat_fire_s;

  // MSB-priority reduction: scanning upward, each differing bit overrides lower ones.
  function automatic logic [1:0] slice_verdict(input logic [CHUNK_WIDTH-1:0] a,
                                               input logic [CHUNK_WIDTH-1:0] b);
    logic [CHUNK_WIDTH-1:0] pa;
    logic [CHUNK_WIDTH-1:0] pb;
    logic                   above;
    logic                   below;
    pa    = a & ~b;
    pb    = ~a & b;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      above = pa[i] | (above & ~pb[i]);
      below = pb[i] | (below & ~pa[i]);
    end
    return {above, below};
  endfunction

  // Beat conditioning, slice verdict and next accumulator values.
  always_comb begin
    a_eff_s = a_chunk_i;
    b_eff_s = b_chunk_i;
    if (cnt_r == {CNT_W{1'b0}}) begin
      a_eff_s = a_chunk_i & BEAT0_MASK;
      b_eff_s = b_chunk_i & BEAT0_MASK;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
      // Flipping the sign bit maps two's complement order onto unsigned order.
      a_eff_s[SIGN_POS] = ~a_eff_s[SIGN_POS];
      b_eff_s[SIGN_POS] = ~b_eff_s[SIGN_POS];
`endif
    end else begin
      a_eff_s = a_chunk_i;
      b_eff_s = b_chunk_i;
    end
    {slice_above_s, slice_below_s} = slice_verdict(a_eff_s, b_eff_s);
    acc_above_nx_s = acc_above_r | (slice_above_s & ~acc_below_r);
    acc_below_nx_s = acc_below_r | (slice_below_s & ~acc_above_r);
    beat_fire_s    = chunk_valid_i & chunk_ready_o;
  end

  // Control FSM with registered handshake and verdict outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= ACCUM;
      cnt_r          <= {CNT_W{1'b0}};
      acc_above_r    <= 1'b0;
      acc_below_r    <= 1'b0;
      chunk_ready_o  <= 1'b1;
      result_valid_o <= 1'b0;
      above_o        <= 1'b0;
      below_o        <= 1'b0;
    end else if (clear_i) begin
      state_r        <= ACCUM;
      cnt_r          <= {CNT_W{1'b0}};
      acc_above_r    <= 1'b0;
      acc_below_r    <= 1'b0;
      chunk_ready_o  <= 1'b1;
      result_valid_o <= 1'b0;
      above_o        <= 1'b0;
      below_o        <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (beat_fire_s) begin
            acc_above_r <= acc_above_nx_s;
            acc_below_r <= acc_below_nx_s;
            if (cnt_r == LAST_CNT) begin
              state_r        <= RESULT;
              cnt_r          <= {CNT_W{1'b0}};
              chunk_ready_o  <= 1'b0;
              result_valid_o <= 1'b1;
              above_o        <= acc_above_nx_s;
              below_o        <= acc_below_nx_s;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RESULT: begin
          if (result_ready_i) begin
            state_r        <= ACCUM;
            cnt_r          <= {CNT_W{1'b0}};
            acc_above_r    <= 1'b0;
            acc_below_r    <= 1'b0;
            chunk_ready_o  <= 1'b1;
            result_valid_o <= 1'b0;
            above_o        <= 1'b0;
            below_o        <= 1'b0;
          end else begin
            result_valid_o <= 1'b1;
          end
        end
        default: begin
          state_r        <= ACCUM;
          cnt_r          <= {CNT_W{1'b0}};
          acc_above_r    <= 1'b0;
          acc_below_r    <= 1'b0;
          chunk_ready_o  <= 1'b1;
          result_valid_o <= 1'b0;
          above_o        <= 1'b0;
          below_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: a 32/8 instance and a padded 12/8 instance.
module tb_serial_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr;
  logic v0, r0_o, rv0, rr0, ab0, bl0;
  logic [7:0] a0, b0;
  logic v1, r1_o, rv1, rr1, ab1, bl1;
  logic [7:0] a1, b1;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic hold0 = 1'b0;
  logic [1:0] held0 = 2'b00;

  serial_comparator #(.WORD_WIDTH(32), .CHUNK_WIDTH(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .chunk_valid_i(v0), .chunk_ready_o(r0_o), .a_chunk_i(a0), .b_chunk_i(b0),
    .result_valid_o(rv0), .result_ready_i(rr0), .above_o(ab0), .below_o(bl0));

  serial_comparator #(.WORD_WIDTH(12), .CHUNK_WIDTH(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .chunk_valid_i(v1), .chunk_ready_o(r1_o), .a_chunk_i(a1), .b_chunk_i(b1),
    .result_valid_o(rv1), .result_ready_i(rr1), .above_o(ab1), .below_o(bl1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Whole-word reference: {A>B, A<B}
  function automatic logic [1:0] ref32(input logic [31:0] a, input logic [31:0] b);
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    return {$signed(a) > $signed(b), $signed(a) < $signed(b)};
`else
    return {a > b, a < b};
`endif
  endfunction

  function automatic logic [1:0] ref12(input logic [11:0] a, input logic [11:0] b);
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    return {$signed(a) > $signed(b), $signed(a) < $signed(b)};
`else
    return {a > b, a < b};
`endif
  endfunction

  task automatic wait_ready0();
    int n = 0;
    while (r0_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("chunk_ready0");
  endtask

  task automatic beat0(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    v0 = 1'b1; a0 = a; b0 = b;
    wait_ready0();
  endtask

  task automatic send0(input logic [31:0] a, input logic [31:0] b, input bit gaps);
    q0.push_back(ref32(a, b));
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          v0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom);
        end
      end
      beat0(a[31-8*k -: 8], b[31-8*k -: 8]);
    end
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic send1(input logic [11:0] a, input logic [11:0] b,
                       input logic [3:0] pa, input logic [3:0] pb);
    int n;
    q1.push_back(ref12(a, b));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v1 = 1'b1;
      a1 = (k == 0) ? {pa, a[11:8]} : a[7:0];
      b1 = (k == 0) ? {pb, b[11:8]} : b[7:0];
      n = 0;
      while (r1_o !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) timeout("chunk_ready1");
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic mon0_step();
    if (!rst_n) begin
      hold0 = 1'b0;
    end else begin
      if (rv0) begin
        chk("exclusive0", 32'(ab0 & bl0), 32'd0);
        if (hold0) chk("hold_stable0", 32'({ab0, bl0}), 32'(held0));
      end
      if (rv0 && rr0 && !clr) begin
        if (q0.size() == 0) timeout("unexpected_result0");
        else chk("verdict0", 32'({ab0, bl0}), 32'(q0.pop_front()));
      end
      hold0 = rv0 && !rr0 && !clr;
      held0 = {ab0, bl0};
    end
  endtask

  task automatic mon1_step();
    if (rst_n && rv1 && rr1 && !clr) begin
      chk("exclusive1", 32'(ab1 & bl1), 32'd0);
      if (q1.size() == 0) timeout("unexpected_result1");
      else chk("verdict1", 32'({ab1, bl1}), 32'(q1.pop_front()));
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       rr0 = 1'($urandom_range(0, 1));
      1:       rr0 = 1'b0;
      default: rr0 = 1'b1;
    endcase
  end

  initial forever begin
    @(negedge clk);
    #1;
    mon0_step();
    mon1_step();
  end

  initial begin
    logic [31:0] ra, rb;
    int n;
    rst_n = 1'b0; clr = 1'b0; rr1 = 1'b1; rr0 = 1'b1;
    v0 = 1'b0; a0 = 8'd0; b0 = 8'd0;
    v1 = 1'b0; a1 = 8'd0; b1 = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(r0_o), 32'd1);
    chk("rst_valid", 32'(rv0), 32'd0);
    chk("rst_above", 32'(ab0), 32'd0);
    chk("rst_below", 32'(bl0), 32'd0);
    rst_n = 1'b1;

    // Latency and post-handshake readiness
    rdy_mode = 2;
    @(negedge clk);
    send0(32'h12345678, 32'h12345679, 1'b0);
    chk("lat_valid", 32'(rv0), 32'd1);
    chk("lat_ready_low", 32'(r0_o), 32'd0);
    @(negedge clk);
    chk("next_ready", 32'(r0_o), 32'd1);
    chk("next_valid", 32'(rv0), 32'd0);
    send0(32'h80000000, 32'h7FFFFFFF, 1'b0);
    send0(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

    // Backpressure on the verdict
    rdy_mode = 1;
    @(negedge clk);
    send0(32'h00FF0000, 32'h01000000, 1'b0);
    chk("bp_valid_rise", 32'(rv0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
      chk("bp_ready_low", 32'(r0_o), 32'd0);
      chk("bp_valid_held", 32'(rv0), 32'd1);
    end
    v0 = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_ready", 32'(r0_o), 32'd1);
    chk("bp_release_valid", 32'(rv0), 32'd0);

    // Abort on beat 2 with a decided partial word
    beat0(8'hFF, 8'h00);
    beat0(8'h11, 8'h22);
    @(negedge clk);
    v0 = 1'b1; a0 = 8'hAA; b0 = 8'h55; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; v0 = 1'b0;
    chk("abort_ready", 32'(r0_o), 32'd1);
    chk("abort_valid", 32'(rv0), 32'd0);
    send0(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

    // Abort while a verdict is pending, even with result_ready high
    rdy_mode = 1;
    @(negedge clk);
    send0(32'h00000001, 32'h00000000, 1'b0);
    rdy_mode = 2;
    @(negedge clk);
    clr = 1'b1;
    void'(q0.pop_back());
    @(negedge clk);
    clr = 1'b0;
    chk("abort_res_valid", 32'(rv0), 32'd0);
    chk("abort_res_ready", 32'(r0_o), 32'd1);
    send0(32'h00000000, 32'h00000001, 1'b0);

    // Asynchronous reset mid-word and while holding a verdict
    beat0(8'h01, 8'h02);
    beat0(8'h03, 8'h04);
    @(negedge clk);
    v0 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("areset_mid_ready", 32'(r0_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    send0(32'hFFFF0000, 32'h0000FFFF, 1'b0);
    chk("pre_areset_valid", 32'(rv0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(rv0), 32'd0);
    chk("areset_ready", 32'(r0_o), 32'd1);
    chk("areset_above", 32'(ab0), 32'd0);
    chk("areset_below", 32'(bl0), 32'd0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 2;
    send0(32'h7FFFFFFF, 32'h80000000, 1'b0);

    // Randomised words with gaps and random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        2:       rb = {ra[31:8], 8'($urandom)};
        default: rb = $urandom;
      endcase
      send0(ra, rb, 1'b1);
    end

    // Padded instance: pad bits must not influence the verdict
    send1(12'h122, 12'h122, 4'hF, 4'h0);
    send1(12'h800, 12'h7FF, 4'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : 32'($urandom);
      send1(ra[11:0], rb[11:0], 4'($urandom), 4'($urandom));
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("drain");
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
